// File: rtl/mctrl_pkg.sv
// mctrl_pkg -- shared definitions for the multicycle MIPS control FSM.
//   state_t      : state codes (also exposed on state_out for debug)
//   OP_* / FN_*  : opcode and R-type funct constants
//   ALU_*        : ALU_Control encodings, shared with ALU_32
//   SRCB_* / PCSRC_* : datapath mux select encodings
//   ctl_t        : registered Moore control word
//   ctl_for()    : control word owned by a given state
// Optional feature macro: MCTRL_BNE_EN (bne support, decoded in mctrl_fsm).
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_EXE  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_IEXE = 4'd10,
    S_IWB  = 4'd11,
    S_TRAP = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write_jmp;   // JMP part of PCWrite; IF part is the handshake
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_control;
  } ctl_t;

  // r_alu: R-type ALU op from the funct decoder; op: opcode held in IR.
  function automatic ctl_t ctl_for(input state_t s, input logic [2:0] r_alu,
                                   input logic [5:0] op, input logic bne_en);
    ctl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read    = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.pc_source   = PCSRC_ALU;
      end
      S_ID: begin
        c.alu_src_b   = SRCB_IMM_SH2;
        c.alu_control = ALU_ADD;
      end
      S_MADR: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
      end
      S_MRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_EXE: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_REGB;
        c.alu_control = r_alu;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REGB;
        c.alu_control   = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.branch_ne     = bne_en && (op == OP_BNE);
      end
      S_JMP: begin
        c.pc_write_jmp = 1'b1;
        c.pc_source    = PCSRC_JUMP;
      end
      S_IEXE: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: c.reg_write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  localparam ctl_t CTL_IF = ctl_for(S_IF, ALU_ADD, OP_RTYPE, 1'b0);

endpackage

// File: rtl/mctrl_fsm_alu_dec.sv
// mctrl_alu_dec -- combinational R-type funct decoder.
//   funct       in  6 : instruction [5:0]
//   alu_control out 3 : ALU operation for the funct
//   legal       out 1 : funct is one of the supported R-type operations
module mctrl_alu_dec
  import mctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      FN_SRL:  alu_control = ALU_SRL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mctrl_fsm.sv
// mctrl_fsm -- multicycle MIPS control unit.
//   clk, rst (async, active high), opcode/funct from IR, zero (ALU flag,
//   consumed by the datapath PC-enable gate), mem_ready (memory handshake).
//   Outputs: datapath strobes and mux selects, sticky illegal flag and
//   state_out (current state code for debug).
// Optional feature: define MCTRL_BNE_EN to decode bne (opcode 0x05) through
// the BEQ state with Branch_ne=1; otherwise 0x05 traps and Branch_ne is 0.
//
// Memory handshake: a memory state (IF, MRD, MWR) presents its request
// (MemRead or MemWrite, held steady) and stays put while mem_ready=0; the
// access completes in the cycle mem_ready=1, and only that cycle may assert
// IRWrite/PCWrite in IF.
module mctrl_fsm
  import mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       Branch_ne,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic       illegal,
  output logic [3:0] state_out
);

`ifdef MCTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_t     state;
  state_t     state_nxt;
  ctl_t       ctl;
  logic [2:0] r_alu;
  logic       r_legal;
  logic       if_done;
  logic       unused_zero;

  // zero only matters to the datapath, which gates PC load with it.
  assign unused_zero = zero;

  mctrl_alu_dec u_alu_dec (
    .funct       (funct),
    .alu_control (r_alu),
    .legal       (r_legal)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:   if (mem_ready) state_nxt = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:     state_nxt = S_MADR;
          OP_RTYPE:         state_nxt = S_EXE;
          OP_BEQ:           state_nxt = S_BEQ;
          OP_BNE:           state_nxt = BNE_EN ? S_BEQ : S_TRAP;
          OP_J:             state_nxt = S_JMP;
          OP_ADDI, OP_SLTI: state_nxt = S_IEXE;
          default:          state_nxt = S_TRAP;
        endcase
      end
      S_MADR: state_nxt = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:  if (mem_ready) state_nxt = S_MWB;
      S_MWR:  if (mem_ready) state_nxt = S_IF;
      S_EXE:  state_nxt = r_legal ? S_RWB : S_TRAP;
      S_IEXE: state_nxt = S_IWB;
      S_TRAP: state_nxt = S_TRAP;
      S_MWB, S_RWB, S_BEQ, S_JMP, S_IWB: state_nxt = S_IF;
      default: state_nxt = S_IF;
    endcase
  end

  // Control word is registered alongside the state it belongs to, so every
  // Moore output is glitch-free and reset lands directly on the IF values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IF;
      ctl     <= CTL_IF;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctl     <= ctl_for(state_nxt, r_alu, opcode, BNE_EN);
      illegal <= (state_nxt == S_TRAP);
    end
  end

  // Fetch completion is the only Mealy term; it never fires during reset.
  assign if_done = (state == S_IF) && mem_ready && !rst;

  assign PCWrite     = ctl.pc_write_jmp | if_done;
  assign IRWrite     = if_done;
  assign PCWriteCond = ctl.pc_write_cond;
  assign Branch_ne   = ctl.branch_ne;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign PCSource    = ctl.pc_source;
  assign ALU_Control = ctl.alu_control;
  assign state_out   = state;

endmodule

// File: tb/tb_mctrl_fsm.sv
// tb_mctrl_fsm -- self-checking bench for mctrl_fsm: instruction-path model
// with per-cycle output compare, directed literal scenarios, random programs.
module tb_mctrl_fsm;

`ifdef MCTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = '0;
  logic [5:0] funct  = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state_out;

  mctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch_ne(Branch_ne), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .illegal(illegal), .state_out(state_out)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // {legal, alu code} for an R-type funct.
  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b1_010;
      6'h22: return 4'b1_110;
      6'h24: return 4'b1_000;
      6'h25: return 4'b1_001;
      6'h26: return 4'b1_011;
      6'h27: return 4'b1_100;
      6'h2A: return 4'b1_111;
      6'h02: return 4'b1_101;
      default: return 4'b0_000;
    endcase
  endfunction

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    logic       ill;
    logic       c_iord, c_m2r, c_rd, c_asa, c_asb, c_pcs, c_alu;
  } exp_t;

  function automatic exp_t expect_of(input int s, input logic [5:0] op,
                                     input logic [5:0] fn, input logic mr);
    exp_t e;
    logic [3:0] a;
    e = '0;
    a = alu_of(fn);
    case (s)
      0: begin
        e.mrd = 1; e.irw = mr; e.pcw = mr; e.asb = 2'b01; e.alu = 3'b010;
        {e.c_iord, e.c_asa, e.c_asb, e.c_pcs, e.c_alu} = '1;
      end
      1: begin e.asb = 2'b11; e.alu = 3'b010; {e.c_asa, e.c_asb, e.c_alu} = '1; end
      2: begin e.asa = 1; e.asb = 2'b10; e.alu = 3'b010; {e.c_asa, e.c_asb, e.c_alu} = '1; end
      3: begin e.mrd = 1; e.iord = 1; e.c_iord = 1; end
      4: begin e.rw = 1; e.m2r = 1; e.rd = 0; {e.c_m2r, e.c_rd} = '1; end
      5: begin e.mwr = 1; e.iord = 1; e.c_iord = 1; end
      6: begin e.asa = 1; e.asb = 2'b00; e.alu = a[2:0]; {e.c_asa, e.c_asb} = '1; e.c_alu = a[3]; end
      7: begin e.rw = 1; e.rd = 1; e.m2r = 0; {e.c_m2r, e.c_rd} = '1; end
      8: begin
        e.asa = 1; e.asb = 2'b00; e.alu = 3'b110; e.pcwc = 1; e.pcs = 2'b01;
        e.bne = BNE_EN && (op == 6'h05);
        {e.c_asa, e.c_asb, e.c_alu, e.c_pcs} = '1;
      end
      9: begin e.pcw = 1; e.pcs = 2'b10; e.c_pcs = 1; end
      10: begin
        e.asa = 1; e.asb = 2'b10; e.alu = (op == 6'h0A) ? 3'b111 : 3'b010;
        {e.c_asa, e.c_asb, e.c_alu} = '1;
      end
      11: begin e.rw = 1; e.rd = 0; e.m2r = 0; {e.c_m2r, e.c_rd} = '1; end
      12: e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Model: states remaining for the current instruction, filled at decode.
  int m_state = 0;
  int path_q[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0;
      path_q.delete();
    end else begin
      case (m_state)
        0: if (mem_ready) m_state = 1;
        1: begin
          path_q.delete();
          case (opcode)
            6'h23: path_q = '{2, 3, 4};
            6'h2B: path_q = '{2, 5};
            6'h00: if (alu_of(funct) >= 4'b1000) path_q = '{6, 7}; else path_q = '{6, 12};
            6'h04: path_q = '{8};
            6'h05: if (BNE_EN) path_q = '{8}; else path_q = '{12};
            6'h02: path_q = '{9};
            6'h08, 6'h0A: path_q = '{10, 11};
            default: path_q = '{12};
          endcase
          m_state = path_q.pop_front();
        end
        3, 5: if (mem_ready) m_state = (path_q.size() == 0) ? 0 : path_q.pop_front();
        12: ;
        default: m_state = (path_q.size() == 0) ? 0 : path_q.pop_front();
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && model_on) begin
      e = expect_of(m_state, opcode, funct, mem_ready);
      chk("state_out", 32'(state_out), 32'(m_state));
      chk("PCWrite", 32'(PCWrite), 32'(e.pcw));
      chk("PCWriteCond", 32'(PCWriteCond), 32'(e.pcwc));
      chk("Branch_ne", 32'(Branch_ne), 32'(e.bne));
      chk("MemRead", 32'(MemRead), 32'(e.mrd));
      chk("MemWrite", 32'(MemWrite), 32'(e.mwr));
      chk("IRWrite", 32'(IRWrite), 32'(e.irw));
      chk("RegWrite", 32'(RegWrite), 32'(e.rw));
      chk("illegal", 32'(illegal), 32'(e.ill));
      if (e.c_iord) chk("IorD", 32'(IorD), 32'(e.iord));
      if (e.c_m2r)  chk("MemtoReg", 32'(MemtoReg), 32'(e.m2r));
      if (e.c_rd)   chk("RegDst", 32'(RegDst), 32'(e.rd));
      if (e.c_asa)  chk("ALUSrcA", 32'(ALUSrcA), 32'(e.asa));
      if (e.c_asb)  chk("ALUSrcB", 32'(ALUSrcB), 32'(e.asb));
      if (e.c_pcs)  chk("PCSource", 32'(PCSource), 32'(e.pcs));
      if (e.c_alu)  chk("ALU_Control", 32'(ALU_Control), 32'(e.alu));
    end
  end

  // ---------------- driver tasks ----------------
  // Cursor sits 1 time unit after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input logic mr, input logic z);
    mem_ready = mr;
    zero = z;
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Fetch (IF with mem_ready=1) and present op/fn once in ID.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    cyc(1, 0);
    tick();
    opcode = op;
    funct = fn;
    cyc(1, 0);
    chk("lit_id_state", 32'(state_out), 32'd1);
    tick();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    int  n = 0;
    bit  seen_id = 0;
    bit  done = 0;
    while (!done) begin
      if (m_state == 1) begin
        opcode = op; funct = fn; seen_id = 1;
      end else if (m_state == 0) begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      cyc(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
      tick();
      n++;
      if ((seen_id && m_state == 0) || m_state == 12) done = 1;
      else if (n > 60) begin
        checks++; errors++;
        $display("FAIL instr_timeout: got %0d cycles required <= 60", n);
        done = 1;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [5:0] FN_TAB [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};

  initial begin
    logic [5:0] op, fn;
    int r;
    rst = 1'b1;
    repeat (2) tick();

    // Reset state
    cyc(0, 0);
    chk("lit_rst_state", 32'(state_out), 32'd0);
    chk("lit_rst_memread", 32'(MemRead), 32'd1);
    chk("lit_rst_iord", 32'(IorD), 32'd0);
    chk("lit_rst_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("lit_rst_alu", 32'(ALU_Control), 32'd2);
    chk("lit_rst_illegal", 32'(illegal), 32'd0);
    chk("lit_rst_irwrite", 32'(IRWrite), 32'd0);
    rst = 1'b0;
    model_on = 1'b1;
    tick();

    // Fetch wait x3, then handshake; then sub through EXE/RWB
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk("lit_if_wait_state", 32'(state_out), 32'd0);
      chk("lit_if_wait_irw", 32'(IRWrite), 32'd0);
      chk("lit_if_wait_pcw", 32'(PCWrite), 32'd0);
      tick();
    end
    cyc(1, 0);
    chk("lit_if_done_irw", 32'(IRWrite), 32'd1);
    chk("lit_if_done_pcw", 32'(PCWrite), 32'd1);
    tick();
    opcode = 6'h00; funct = 6'h22;
    cyc(1, 0);
    chk("lit_sub_id", 32'(state_out), 32'd1);
    chk("lit_sub_id_irw", 32'(IRWrite), 32'd0);
    tick();
    cyc(1, 0);
    chk("lit_sub_exe", 32'(state_out), 32'd6);
    chk("lit_sub_alu", 32'(ALU_Control), 32'b110);
    tick();
    cyc(1, 0);
    chk("lit_sub_rwb", 32'(state_out), 32'd7);
    chk("lit_sub_rwb_rw_rd", 32'({RegWrite, RegDst}), 32'b11);
    tick();

    // lw with mem_ready=1 throughout
    fetch_decode(6'h23, 6'h00);
    cyc(1, 0); chk("lit_lw_madr", 32'(state_out), 32'd2); tick();
    cyc(1, 0); chk("lit_lw_mrd", 32'(state_out), 32'd3); tick();
    cyc(1, 0);
    chk("lit_lw_mwb", 32'(state_out), 32'd4);
    chk("lit_lw_mwb_m2r_rw", 32'({MemtoReg, RegWrite}), 32'b11);
    tick();

    // beq not taken, zero=0
    fetch_decode(6'h04, 6'h00);
    cyc(1, 0);
    chk("lit_beq_state", 32'(state_out), 32'd8);
    chk("lit_beq_cond_pcw", 32'({PCWriteCond, PCWrite}), 32'b10);
    tick();

    // bne, zero=0: branch state with Branch_ne when built in, trap otherwise
    fetch_decode(6'h05, 6'h00);
    cyc(1, 0);
    chk("lit_bne_state", 32'(state_out), BNE_EN ? 32'd8 : 32'd12);
    chk("lit_bne_flag", 32'(Branch_ne), 32'(BNE_EN));
    chk("lit_bne_illegal", 32'(illegal), 32'(!BNE_EN));
    tick();
    reset_pulse();

    // Undecodable opcode: trap held with strobes low, reset clears
    fetch_decode(6'h3F, 6'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      chk("lit_trap_state", 32'(state_out), 32'd12);
      chk("lit_trap_illegal", 32'(illegal), 32'd1);
      chk("lit_trap_strobes", 32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("lit_trap_rst_illegal", 32'(illegal), 32'd0);
    chk("lit_trap_rst_state", 32'(state_out), 32'd0);
    tick();
    rst = 1'b0;

    // Asynchronous reset in the middle of an MRD wait
    fetch_decode(6'h23, 6'h00);
    cyc(1, 0); tick();
    cyc(0, 0);
    chk("lit_mrd_state", 32'(state_out), 32'd3);
    chk("lit_mrd_iord", 32'(IorD), 32'd1);
    rst = 1'b1;
    #1;
    chk("lit_async_state", 32'(state_out), 32'd0);
    chk("lit_async_memread", 32'(MemRead), 32'd1);
    chk("lit_async_iord", 32'(IorD), 32'd0);
    tick();
    rst = 1'b0;

    // Random programs
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 19);
      fn = FN_TAB[$urandom_range(0, 7)];
      case (r)
        0, 1, 2, 3: op = 6'h00;
        4:          begin op = 6'h00; fn = 6'($urandom); end
        5, 6, 19:   op = 6'h23;
        7, 8:       op = 6'h2B;
        9, 10:      op = 6'h04;
        11:         op = 6'h05;
        12, 13:     op = 6'h02;
        14, 15:     op = 6'h08;
        16, 17:     op = 6'h0A;
        default:    op = 6'($urandom);
      endcase
      run_instr(op, fn);
      if (m_state == 12) begin
        repeat (4) begin
          cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
          tick();
        end
        reset_pulse();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mctrl_fsm.md
MCTRL_FSM -- requirements
Module: mctrl_fsm

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 opcode  in  6  instruction [31:26], sampled from the datapath instruction register.
REQ-004 funct  in  6  instruction [5:0].
REQ-005 zero  in  1  ALU zero flag from the datapath.
REQ-006 mem_ready  in  1  memory access-complete handshake.
REQ-007 PCWrite, PCWriteCond, Branch_ne  out  1 each  unconditional PC load; load on zero; invert zero for bne.
REQ-008 IorD, MemRead, MemWrite, IRWrite  out  1 each  address select (1=ALUOut); memory read and write strobes; instruction-register load.
REQ-009 MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  write-back select; destination rd; register-file write; ALU A=register A.
REQ-010 ALUSrcB  out  2  00 regB, 01 constant 4, 10 Imm_32, 11 Imm_32<<2.
REQ-011 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
REQ-012 ALU_Control  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
REQ-013 illegal  out  1  sticky undecodable-instruction flag.
REQ-014 state_out  out  4  current state code, for debug and verification.

Function
REQ-015 States and codes: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXE=6, RWB=7, BEQ=8, JMP=9, IEXE=10, IWB=11, TRAP=12; Moore outputs, except the REQ-016 handshake strobes.
REQ-016 IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00; stay while mem_ready=0; IRWrite and PCWrite are asserted only in the cycle where mem_ready=1, followed by ID.
REQ-017 ID: ALUSrcA=0, ALUSrcB=11, add (branch target); next state by opcode: 0x23/0x2B->MADR, 0x00->EXE, 0x04->BEQ, 0x02->JMP, 0x08/0x0A->IEXE, other->TRAP.
REQ-018 MADR: ALUSrcA=1, ALUSrcB=10, add; lw->MRD, sw->MWR.
REQ-019 MRD: MemRead=1, IorD=1, hold until mem_ready=1 then MWB. MWR: MemWrite=1, IorD=1, hold until mem_ready=1 then IF.
REQ-020 MWB: RegWrite=1, MemtoReg=1, RegDst=0, then IF.
REQ-021 EXE: ALUSrcA=1, ALUSrcB=00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x02 srl -> RWB; any other funct -> TRAP with no register write.
REQ-022 RWB: RegWrite=1, RegDst=1, MemtoReg=0, then IF.
REQ-023 BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, then IF; PC loads only when zero=1 in that cycle.
REQ-024 JMP: PCWrite=1, PCSource=10, then IF.
REQ-025 IEXE: ALUSrcA=1, ALUSrcB=10, add (0x08) or slt (0x0A), then IWB; IWB: RegWrite=1, RegDst=0, MemtoReg=0, then IF.
REQ-026 TRAP: all strobes 0; illegal=1; the state is held until reset.
REQ-027 Write strobes (RegWrite, MemWrite, PCWrite, IRWrite) SHALL never be asserted in the same cycle as an unserviced wait (mem_ready=0), except MemWrite, which is held steady across the wait.
REQ-028 CPI: R-type/addi/slti 4, lw 5, sw 4, beq/j 3, plus one per wait cycle.

Reset
REQ-029 rst=1 forces state IF, illegal=0, and all strobes to their IF values within the same cycle, independent of clk; an access aborted mid-wait restarts at IF.

Configuration
REQ-030 MCTRL_BNE_EN defined: opcode 0x05 in ID goes to BEQ with Branch_ne=1 (PC loads when zero=0); undefined: Branch_ne is tied 0 and 0x05 goes to TRAP.

Structure
REQ-031 Shared package holds the state codes, opcode/funct constants and ALU_Control encodings, which are also used by ALU_32.
REQ-032 Natural sub-module: mctrl_alu_dec (funct to ALU_Control, plus a legal flag), combinational.

Verification
REQ-033 rst pulsed mid-MRD with mem_ready=0 -> state_out=0, MemRead=1, IorD=0 at once.
REQ-034 IF with mem_ready low for 3 cycles then high -> IRWrite/PCWrite high for exactly 1 cycle, then state_out=1.
REQ-035 opcode 0x00, funct 0x22 -> states 0,1,6,7; ALU_Control=110 in EXE; RegWrite=1, RegDst=1 in RWB.
REQ-036 opcode 0x23 with mem_ready=1 -> states 0,1,2,3,4; MemtoReg=1, RegWrite=1 in state 4.
REQ-037 opcode 0x04, zero=0 -> PCWriteCond=1 with no PC load; bne (0x05), zero=0 with macro -> Branch_ne=1; without macro -> state_out=12.
REQ-038 opcode 0x3F -> state_out=12, illegal=1, no strobes held for 10 cycles; rst clears illegal.
